// File: rtl/bcd_serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub_pkg
// Shared definitions for the serial BCD subtractor: FSM state encoding, the
// default operand width in digits and the largest legal BCD digit value.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int         DIGITS_DEFAULT = 4;
    localparam logic [3:0] BCD_MAX        = 4'd9;

    // A nibble is a legal BCD digit only in the range 0..9.
    function automatic logic nibble_invalid(input logic [3:0] n);
        return (n > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_sub_if.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub_if
// Request/result bundle of the serial BCD subtractor.
//   start   : request pulse (master -> slave)
//   a, b    : packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   busy    : operation in progress (slave -> master)
//   done    : one-cycle completion pulse
//   diff    : packed BCD result a-b modulo 10^DIGITS
//   borrow  : a < b
//   invalid : a captured nibble exceeded 9
// Modports: master (requester), slave (subtractor).
// -----------------------------------------------------------------------------
interface bcd_serial_sub_if
    import bcd_serial_sub_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  borrow;
    logic                  invalid;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, invalid
    );
endinterface

// File: rtl/bcd_serial_sub_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtractor: d = x - y - bin, wrapped into
// 0..9 with a borrow out when the raw difference goes negative.
//   x    : minuend digit
//   y    : subtrahend digit
//   bin  : borrow in
//   d    : result digit
//   bout : borrow out
// -----------------------------------------------------------------------------
module bcd_digit_sub (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    // 5-bit signed covers 0-9-1 = -10 up to 9 - 0 - 0 = 9 with room to spare.
    logic signed [4:0] t;
    logic signed [4:0] t_adj;

    always_comb begin
        t     = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
        bout  = t[4];
        t_adj = bout ? (t + 5'sd10) : t;
        d     = t_adj[3:0];
    end
endmodule

// File: rtl/bcd_serial_sub.sv
// -----------------------------------------------------------------------------
// bcd_serial_sub
// Digit-serial packed-BCD subtractor. A start in IDLE captures a and b, then
// one digit per cycle is subtracted LSD first, and the result is published
// with a one-cycle done pulse. Published outputs only change on that pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bcd_serial_sub_if.slave (start, a, b in; busy, done, diff,
//          borrow, invalid out)
// -----------------------------------------------------------------------------
module bcd_serial_sub
    import bcd_serial_sub_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    bcd_serial_sub_if.slave    bus
);
    localparam int                W        = 4 * DIGITS;
    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               brw_q, brw_d;       // running borrow between digits
    logic               inv_q, inv_d;       // operand validity seen at capture
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               invalid_q, invalid_d;

    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       res_q, res_d;       // result being assembled

    logic [3:0]         dig_d;
    logic               dig_bout;

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | nibble_invalid(v[4*i +: 4]);
        end
        return bad;
    endfunction

    // The operands shift right each RUN cycle, so the live digit is always
    // in the bottom nibble.
    bcd_digit_sub u_digit (
        .x    (a_sh_q[3:0]),
        .y    (b_sh_q[3:0]),
        .bin  (brw_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        brw_d     = brw_q;
        inv_d     = inv_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        invalid_d = invalid_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    idx_d   = '0;
                    brw_d   = 1'b0;
                    inv_d   = any_invalid(bus.a) | any_invalid(bus.b);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 4;
                b_sh_d = b_sh_q >> 4;
                // New digit enters at the top; after DIGITS shifts digit 0
                // has arrived at the bottom.
                res_d  = (res_q >> 4) | (W'(dig_d) << (W - 4));
                brw_d  = dig_bout;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                invalid_d = inv_q;
                diff_d    = inv_q ? '0 : res_q;
                borrow_d  = inv_q ? 1'b0 : brw_q;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        a_sh_q <= a_sh_d;
        b_sh_q <= b_sh_d;
        res_q  <= res_d;
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            brw_q     <= 1'b0;
            inv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            brw_q     <= brw_d;
            inv_q     <= inv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.diff    = diff_q;
    assign bus.borrow  = borrow_q;
    assign bus.invalid = invalid_q;

endmodule
